// File: rtl/noc_vc_arbiter_pkg.sv
// rtl/noc_vc_arbiter_pkg.sv - shared NoC VC arbiter types and defaults
package Noc_parameters;

    localparam int Noc_VC_Channel     = 4;
    localparam int Noc_VC_Stall_Limit = 1024;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_LOCK = 1'b1
    } arb_state_e;

endpackage

// File: rtl/noc_vc_arbiter_if.sv
// rtl/noc_vc_arbiter_if.sv - per-VC flit markers, accept strobe and grant bundle
interface noc_vc_arbiter_if
    import Noc_parameters::*;
#(
    parameter int CHANNELS = Noc_VC_Channel
);

    logic [CHANNELS-1:0] i_valid;
    logic [CHANNELS-1:0] i_head;
    logic [CHANNELS-1:0] i_tail;
    logic                i_accept;
    logic [CHANNELS-1:0] o_vc_grant;
    logic                o_busy;
    logic                o_stall_err;

    modport master (
        output i_valid, i_head, i_tail, i_accept,
        input  o_vc_grant, o_busy, o_stall_err
    );

    modport slave (
        input  i_valid, i_head, i_tail, i_accept,
        output o_vc_grant, o_busy, o_stall_err
    );

endinterface

// File: rtl/noc_vc_arbiter_rr_pick.sv
// rtl/noc_vc_arbiter_rr_pick.sv - combinational round-robin pick (module noc_rr_pick)
module noc_rr_pick #(
    parameter int CHANNELS = 4,
    parameter int IW       = 2
) (
    input  logic [CHANNELS-1:0] req_i,
    input  logic [IW-1:0]       ptr_i,
    output logic [CHANNELS-1:0] grant_o,
    output logic [IW-1:0]       idx_o,
    output logic                any_o
);

    logic [IW:0]         start;
    logic [IW:0]         sum;
    logic [CHANNELS-1:0] rot;

    assign start = {1'b0, ptr_i} + (IW+1)'(1);

    // Rotate via the doubled request vector so bit 0 of rot is VC (ptr+1) mod CHANNELS.
    always_comb begin
        rot     = CHANNELS'({req_i, req_i} >> start);
        any_o   = 1'b0;
        sum     = '0;
        idx_o   = '0;
        grant_o = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (!any_o && rot[k]) begin
                any_o = 1'b1;
                sum   = start + (IW+1)'(k);
            end
        end
        if (sum >= (IW+1)'(CHANNELS)) begin
            sum = sum - (IW+1)'(CHANNELS);
        end
        idx_o = sum[IW-1:0];
        if (any_o) begin
            grant_o[idx_o] = 1'b1;
        end
    end

endmodule

// File: rtl/noc_vc_arbiter.sv
// rtl/noc_vc_arbiter.sv - packet-locked round-robin VC grant; optional watchdog via NOC_VC_ARB_WATCHDOG_EN
module noc_vc_arbiter
    import Noc_parameters::*;
#(
    parameter int CHANNELS    = Noc_VC_Channel,
    parameter int STALL_LIMIT = Noc_VC_Stall_Limit
) (
    input  logic            noc_clk,
    input  logic            noc_rst,
    noc_vc_arbiter_if.slave bus
);

    localparam int IW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    if (CHANNELS < 2 || STALL_LIMIT < 1) begin : g_bad_cfg
        $error("noc_vc_arbiter: CHANNELS must be >= 2 and STALL_LIMIT >= 1");
    end

    arb_state_e          state_q, state_d;
    logic [CHANNELS-1:0] grant_q, grant_d;
    logic [IW-1:0]       ptr_q, ptr_d;

    logic [CHANNELS-1:0] req;
    logic [CHANNELS-1:0] pick_grant;
    logic [IW-1:0]       pick_idx;
    logic                pick_any;
    logic                tail_done;

    assign req       = bus.i_valid & bus.i_head;
    assign tail_done = bus.i_accept && |(grant_q & bus.i_tail);

    // ptr_q already names the current holder, so at a tail it gets lowest priority.
    noc_rr_pick #(
        .CHANNELS (CHANNELS),
        .IW       (IW)
    ) u_pick (
        .req_i   (req),
        .ptr_i   (ptr_q),
        .grant_o (pick_grant),
        .idx_o   (pick_idx),
        .any_o   (pick_any)
    );

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        case (state_q)
            ARB_IDLE: begin
                if (pick_any) begin
                    grant_d = pick_grant;
                    ptr_d   = pick_idx;
                    state_d = ARB_LOCK;
                end
            end
            ARB_LOCK: begin
                if (tail_done) begin
                    if (pick_any) begin
                        grant_d = pick_grant;
                        ptr_d   = pick_idx;
                    end else begin
                        grant_d = '0;
                        state_d = ARB_IDLE;
                    end
                end
            end
            default: begin
                grant_d = '0;
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge noc_clk) begin
        if (noc_rst) begin
            state_q <= ARB_IDLE;
            grant_q <= '0;
            ptr_q   <= IW'(CHANNELS - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
        end
    end

    assign bus.o_vc_grant = grant_q;
    assign bus.o_busy     = (state_q == ARB_LOCK);

`ifdef NOC_VC_ARB_WATCHDOG_EN
    localparam int             CW    = $clog2(STALL_LIMIT + 1);
    localparam logic [CW-1:0]  LIMIT = CW'(STALL_LIMIT);

    logic [CW-1:0] wd_cnt_q, wd_cnt_d;
    logic          stall_err_q, stall_err_d;

    always_comb begin
        wd_cnt_d = wd_cnt_q;
        if (state_q == ARB_IDLE || bus.i_accept) begin
            wd_cnt_d = '0;
        end else if (wd_cnt_q != LIMIT) begin
            wd_cnt_d = wd_cnt_q + CW'(1);
        end
        stall_err_d = stall_err_q | (wd_cnt_d == LIMIT);
    end

    always_ff @(posedge noc_clk) begin
        if (noc_rst) begin
            wd_cnt_q    <= '0;
            stall_err_q <= 1'b0;
        end else begin
            wd_cnt_q    <= wd_cnt_d;
            stall_err_q <= stall_err_d;
        end
    end

    assign bus.o_stall_err = stall_err_q;
`else
    assign bus.o_stall_err = 1'b0;
`endif

endmodule

// File: tb/tb_noc_vc_arbiter.sv
// tb/tb_noc_vc_arbiter.sv - directed vector bench for noc_vc_arbiter at CHANNELS=4
module tb_noc_vc_arbiter;

`ifdef NOC_VC_ARB_WATCHDOG_EN
    localparam bit WD = 1'b1;
`else
    localparam bit WD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    noc_vc_arbiter_if #(.CHANNELS(4)) bus ();

    noc_vc_arbiter #(
        .CHANNELS    (4),
        .STALL_LIMIT (8)
    ) dut (
        .noc_clk (clk),
        .noc_rst (rst),
        .bus     (bus)
    );

    typedef struct {
        logic       r;
        logic [3:0] v;
        logic [3:0] h;
        logic [3:0] t;
        logic       a;
        logic [3:0] g;
        logic       b;
    } vec_t;

    vec_t tbl[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic [3:0] v, input logic [3:0] h,
                        input logic [3:0] t, input logic a);
        @(negedge clk);
        rst          = r;
        bus.i_valid  = v;
        bus.i_head   = h;
        bus.i_tail   = t;
        bus.i_accept = a;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.i_valid  = '0;
        bus.i_head   = '0;
        bus.i_tail   = '0;
        bus.i_accept = 1'b0;

        //               r     v        h        t        a     grant    busy
        tbl.push_back('{1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0});
        tbl.push_back('{1'b0, 4'b0101, 4'b0101, 4'b0000, 1'b0, 4'b0001, 1'b1});
        tbl.push_back('{1'b0, 4'b0101, 4'b0101, 4'b0000, 1'b1, 4'b0001, 1'b1});
        tbl.push_back('{1'b0, 4'b0101, 4'b0100, 4'b0000, 1'b1, 4'b0001, 1'b1});
        tbl.push_back('{1'b0, 4'b0101, 4'b0100, 4'b0001, 1'b1, 4'b0100, 1'b1});
        tbl.push_back('{1'b0, 4'b0100, 4'b0100, 4'b0000, 1'b0, 4'b0100, 1'b1});
        tbl.push_back('{1'b0, 4'b0100, 4'b0000, 4'b0100, 1'b1, 4'b0000, 1'b0});
        tbl.push_back('{1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0});
        tbl.push_back('{1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0});
        tbl.push_back('{1'b0, 4'b1111, 4'b1111, 4'b1111, 1'b0, 4'b0001, 1'b1});
        tbl.push_back('{1'b0, 4'b1111, 4'b1111, 4'b1111, 1'b1, 4'b0010, 1'b1});
        tbl.push_back('{1'b0, 4'b1111, 4'b1111, 4'b1111, 1'b1, 4'b0100, 1'b1});
        tbl.push_back('{1'b0, 4'b1111, 4'b1111, 4'b1111, 1'b1, 4'b1000, 1'b1});
        tbl.push_back('{1'b0, 4'b1111, 4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b1});
        tbl.push_back('{1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0001, 1'b1});
        tbl.push_back('{1'b0, 4'b0001, 4'b0000, 4'b0001, 1'b1, 4'b0000, 1'b0});
        tbl.push_back('{1'b0, 4'b1010, 4'b1010, 4'b0000, 1'b0, 4'b0010, 1'b1});
        for (int i = 0; i < 5; i++)
            tbl.push_back('{1'b0, 4'b1000, 4'b1000, 4'b0000, 1'b0, 4'b0010, 1'b1});
        tbl.push_back('{1'b0, 4'b1010, 4'b1000, 4'b0010, 1'b1, 4'b1000, 1'b1});
        tbl.push_back('{1'b1, 4'b1000, 4'b1000, 4'b0000, 1'b1, 4'b0000, 1'b0});
        tbl.push_back('{1'b0, 4'b1001, 4'b1001, 4'b0000, 1'b0, 4'b0001, 1'b1});
        tbl.push_back('{1'b0, 4'b0001, 4'b0000, 4'b0001, 1'b1, 4'b0000, 1'b0});

        foreach (tbl[i]) begin
            step(tbl[i].r, tbl[i].v, tbl[i].h, tbl[i].t, tbl[i].a);
            check($sformatf("row%0d grant", i), bus.o_vc_grant, tbl[i].g);
            check($sformatf("row%0d busy", i), {3'b0, bus.o_busy}, {3'b0, tbl[i].b});
            check($sformatf("row%0d stall_err", i), {3'b0, bus.o_stall_err}, 4'b0000);
            check($sformatf("row%0d onehot0", i), {3'b0, $onehot0(bus.o_vc_grant)}, 4'b0001);
        end

        // Stall: lock VC2 and withhold accept for 8 cycles, then finish the packet.
        step(1'b0, 4'b0100, 4'b0100, 4'b0000, 1'b0);
        check("stall lock grant", bus.o_vc_grant, 4'b0100);
        for (int k = 1; k <= 8; k++) begin
            step(1'b0, 4'b0100, 4'b0000, 4'b0000, 1'b0);
            check($sformatf("stall%0d grant held", k), bus.o_vc_grant, 4'b0100);
            check($sformatf("stall%0d err", k), {3'b0, bus.o_stall_err},
                  {3'b0, (WD && k >= 8)});
        end
        step(1'b0, 4'b0100, 4'b0000, 4'b0100, 1'b1);
        check("stall tail grant", bus.o_vc_grant, 4'b0000);
        check("stall err sticky", {3'b0, bus.o_stall_err}, {3'b0, WD});
        step(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        check("stall err idle", {3'b0, bus.o_stall_err}, {3'b0, WD});
        step(1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        check("stall err reset", {3'b0, bus.o_stall_err}, 4'b0000);

        // Single-flit packet granted then accepted; VC0 does not re-win against VC1.
        step(1'b0, 4'b0011, 4'b0011, 4'b0011, 1'b0);
        check("sf first grant", bus.o_vc_grant, 4'b0001);
        step(1'b0, 4'b0011, 4'b0011, 4'b0011, 1'b1);
        check("sf rotate", bus.o_vc_grant, 4'b0010);
        step(1'b0, 4'b0000, 4'b0000, 4'b0010, 1'b1);
        check("sf release", bus.o_vc_grant, 4'b0000);
        check("sf busy", {3'b0, bus.o_busy}, 4'b0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
